// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with start/done run control,
// stall hold, halt detection and a retired-instruction watchdog.
module pc_sequencer #(
    parameter int D         = 12,
    parameter int CW        = 16,
    parameter int MAX_INSTR = 2**16-1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic [D-1:0]  next_target,
    input  logic          stall,
    input  logic          halt,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INSTR);
    state_t        state, state_nx;
    logic [CW-1:0] cnt_inc;
    logic          wd_hit;
    assign cnt_inc = instr_count + CW'(1);
    assign wd_hit  = cnt_inc == MAX_C;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // start is only honoured outside RUN; stall masks both halt and the watchdog
    always_comb begin
        state_nx = state;
        if (state != RUN) state_nx = start ? RUN : state;
        else              state_nx = (!stall && (halt || wd_hit)) ? DONE : RUN;
    end
    always_comb begin
        busy        = state == RUN;
        fetch_valid = state == RUN;
        done        = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ctr    <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                prog_ctr    <= start_addr;
                instr_count <= '0;
                timeout     <= 1'b0;
            end
        end else if (!stall) begin
            if (halt) begin
                instr_count <= cnt_inc;
                timeout     <= 1'b0;
            end else if (wd_hit) begin
                instr_count <= MAX_C;
                timeout     <= 1'b1;
            end else begin
                prog_ctr    <= next_target;
                instr_count <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus an asynchronous-reset sequence
// for pc_sequencer, built with a small watchdog limit.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, stall, halt;
    logic [11:0] start_addr, next_target, prog_ctr;
    logic        fetch_valid, busy, done, timeout;
    logic [15:0] instr_count;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        st;
        logic [11:0] sa, nt;
        logic        sl, hl;
        logic [11:0] pc;
        logic        bz, dn, to;
        logic [15:0] cnt;
    } vec_t;
    vec_t v[$];

    pc_sequencer #(.D(12), .CW(16), .MAX_INSTR(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .next_target(next_target), .stall(stall), .halt(halt),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy),
        .done(done), .timeout(timeout), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [11:0] pc, input logic bz, input logic dn,
                           input logic to, input logic [15:0] cnt);
        chk("prog_ctr", idx, {4'h0, prog_ctr}, {4'h0, pc});
        chk("busy", idx, {15'h0, busy}, {15'h0, bz});
        chk("fetch_valid", idx, {15'h0, fetch_valid}, {15'h0, bz});
        chk("done", idx, {15'h0, done}, {15'h0, dn});
        chk("timeout", idx, {15'h0, timeout}, {15'h0, to});
        chk("instr_count", idx, instr_count, cnt);
    endtask

    task automatic add(input logic st, input logic [11:0] sa, input logic [11:0] nt, input logic sl,
                       input logic hl, input logic [11:0] pc, input logic bz, input logic dn,
                       input logic to, input logic [15:0] cnt);
        vec_t r;
        r.st = st; r.sa = sa; r.nt = nt; r.sl = sl; r.hl = hl;
        r.pc = pc; r.bz = bz; r.dn = dn; r.to = to; r.cnt = cnt;
        v.push_back(r);
    endtask

    initial begin
        // run 1: sequential fetch from 0x010, halt on the fifth instruction
        add(1, 12'h010, 12'h000, 0, 0, 12'h010, 1, 0, 0, 0);
        add(0, 12'h000, 12'h011, 0, 0, 12'h011, 1, 0, 0, 1);
        add(0, 12'h000, 12'h012, 0, 0, 12'h012, 1, 0, 0, 2);
        add(0, 12'h000, 12'h013, 0, 0, 12'h013, 1, 0, 0, 3);
        add(0, 12'h000, 12'h014, 0, 0, 12'h014, 1, 0, 0, 4);
        add(0, 12'h000, 12'h015, 0, 1, 12'h014, 0, 1, 0, 5);
        add(0, 12'h000, 12'h015, 0, 0, 12'h014, 0, 1, 0, 5);
        // run 2: backward jump, start ignored in RUN, wrap 0xFFF -> 0x000
        add(1, 12'h020, 12'h000, 0, 0, 12'h020, 1, 0, 0, 0);
        add(0, 12'h000, 12'h01B, 0, 0, 12'h01B, 1, 0, 0, 1);
        add(1, 12'h100, 12'h01C, 0, 0, 12'h01C, 1, 0, 0, 2);
        add(0, 12'h000, 12'hFFF, 0, 0, 12'hFFF, 1, 0, 0, 3);
        add(0, 12'h000, 12'h000, 0, 0, 12'h000, 1, 0, 0, 4);
        add(0, 12'h000, 12'h001, 0, 1, 12'h000, 0, 1, 0, 5);
        // run 3: stall for three cycles with halt asserted, then halt takes effect
        add(1, 12'h030, 12'h000, 0, 0, 12'h030, 1, 0, 0, 0);
        add(0, 12'h000, 12'h031, 1, 1, 12'h030, 1, 0, 0, 0);
        add(0, 12'h000, 12'h031, 1, 1, 12'h030, 1, 0, 0, 0);
        add(0, 12'h000, 12'h031, 1, 1, 12'h030, 1, 0, 0, 0);
        add(0, 12'h000, 12'h031, 0, 1, 12'h030, 0, 1, 0, 1);
        // run 4: restart from DONE at 0x100, no halt -> watchdog after 8 edges
        add(1, 12'h100, 12'h000, 0, 0, 12'h100, 1, 0, 0, 0);
        for (int i = 1; i < 8; i++)
            add(0, 12'h000, 12'h100 + 12'(i), 0, 0, 12'h100 + 12'(i), 1, 0, 0, 16'(i));
        add(0, 12'h000, 12'h108, 0, 0, 12'h107, 0, 1, 1, 8);
        add(0, 12'h000, 12'h109, 0, 0, 12'h107, 0, 1, 1, 8);
        add(1, 12'h200, 12'h000, 0, 0, 12'h200, 1, 0, 0, 0);

        rst_n = 1'b0; start = 0; stall = 0; halt = 0; start_addr = '0; next_target = '0;
        #12;
        chk_all(-1, 12'h000, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk_all(-2, 12'h000, 0, 0, 0, 0);
        foreach (v[i]) begin
            start = v[i].st; start_addr = v[i].sa; next_target = v[i].nt;
            stall = v[i].sl; halt = v[i].hl;
            @(posedge clk) #1;
            chk_all(i, v[i].pc, v[i].bz, v[i].dn, v[i].to, v[i].cnt);
        end
        // asynchronous reset between edges, then first start right after release
        start = 0; stall = 0; halt = 0; next_target = 12'h201;
        @(posedge clk) #1;
        chk_all(100, 12'h201, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_all(101, 12'h000, 0, 0, 0, 0);
        @(negedge clk) begin rst_n = 1'b1; start = 1; start_addr = 12'h055; end
        @(posedge clk) #1;
        chk_all(102, 12'h055, 1, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
